// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte-stream input and instruction-memory write port of the loader
//
// Purpose: groups the byte-stream handshake and the instruction-memory write
//          port so that the loader and its environment share one bundle.
// Signals:
//   rx_valid    byte available on rx_data            (source -> loader)
//   rx_data     stream byte                          (source -> loader)
//   rx_ready    loader accepts byte                  (loader -> source)
//   imem_we     one-cycle write strobe               (loader -> memory)
//   imem_addr   word index of the write              (loader -> memory)
//   imem_wdata  instruction word to write            (loader -> memory)
// Modports: master = stream source / memory side, slave = loader.
interface imem_loader_if #(
  parameter int ADDR_W = 10
) ();
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output rx_valid,
    output rx_data,
    input  rx_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );

  modport slave (
    input  rx_valid,
    input  rx_data,
    output rx_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - length-prefixed byte-stream loader for the instruction memory
//
// Purpose: receives LEN_LO, LEN_HI (16-bit word count N) and then 4*N bytes,
//          assembles little-endian 32-bit words and writes them to consecutive
//          instruction-memory words. The processor is held in reset until the
//          image is completely loaded.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to expect a trailing XOR
//          checksum byte (XOR of LEN_LO through last data byte); a mismatch
//          ends in the error state.
// Ports:
//   clk            clock, all state changes on posedge
//   rst            asynchronous active-high reset
//   i_start        restart the load from scratch (any state)
//   bus            imem_loader_if.slave: rx_valid/rx_data/rx_ready stream,
//                  imem_we/imem_addr/imem_wdata memory write port
//   o_cpu_rst      processor reset, high until the load is done
//   o_done         image loaded (and checksum verified when enabled)
//   o_error        load failed; sticky until i_start or rst
//   o_words_loaded number of words written so far
module imem_loader #(
  parameter int MEM_DEPTH = 1024,
  parameter int ADDR_W    = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  imem_loader_if.slave      bus,
  output logic              o_cpu_rst,
  output logic              o_done,
  output logic              o_error,
  output logic [ADDR_W:0]   o_words_loaded
);

  typedef enum logic [2:0] {
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_FIN,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [16:0]   LP_DEPTH = 17'(MEM_DEPTH);
  localparam logic [ADDR_W:0] LP_ONE = (ADDR_W+1)'(1);

  state_t            r_state;
  logic [15:0]       r_len;
  logic [23:0]       r_buf;
  logic [1:0]        r_byte_idx;
  logic [ADDR_W:0]   r_words_loaded;
  logic              r_imem_we;
  logic [ADDR_W-1:0] r_imem_addr;
  logic [31:0]       r_imem_wdata;
  logic              r_done;
  logic              r_error;
  logic              r_cpu_rst;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        r_csum;
`endif

  logic              w_rx_ready;
  logic              w_fire;
  logic [15:0]       w_len;
  logic              w_len_too_big;
  logic [ADDR_W:0]   w_next_count;
  logic              w_last_word;

  // start has priority over any byte offered in the same cycle.
  always_comb begin
    w_rx_ready = 1'b0;
    case (r_state)
      S_LEN0, S_LEN1, S_DATA: w_rx_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM:                 w_rx_ready = 1'b1;
`endif
      default:                w_rx_ready = 1'b0;
    endcase
    if (i_start) begin
      w_rx_ready = 1'b0;
    end
  end

  assign w_fire        = bus.rx_valid & w_rx_ready;
  assign w_len         = {bus.rx_data, r_len[7:0]};
  assign w_len_too_big = {1'b0, w_len} > LP_DEPTH;
  assign w_next_count  = r_words_loaded + LP_ONE;
  // The word count doubles as the write word index: both advance together and
  // the length check keeps it below MEM_DEPTH, so no separate counter is kept.
  assign w_last_word   = (16'(w_next_count) == r_len);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_LEN0;
      r_len          <= '0;
      r_buf          <= '0;
      r_byte_idx     <= '0;
      r_words_loaded <= '0;
      r_imem_we      <= 1'b0;
      r_imem_addr    <= '0;
      r_imem_wdata   <= '0;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
      r_cpu_rst      <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_csum         <= '0;
`endif
    end else begin
      r_imem_we <= 1'b0;
      if (i_start) begin
        r_state        <= S_LEN0;
        r_byte_idx     <= '0;
        r_words_loaded <= '0;
        r_done         <= 1'b0;
        r_error        <= 1'b0;
        r_cpu_rst      <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        r_csum         <= '0;
`endif
      end else begin
        case (r_state)
          S_LEN0: begin
            if (w_fire) begin
              r_len[7:0] <= bus.rx_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
              r_csum     <= bus.rx_data;
`endif
              r_state    <= S_LEN1;
            end
          end

          S_LEN1: begin
            if (w_fire) begin
              r_len[15:8] <= bus.rx_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
              r_csum      <= r_csum ^ bus.rx_data;
`endif
              if (w_len_too_big) begin
                r_state <= S_ERR;
                r_error <= 1'b1;
              end else if (w_len == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                r_state   <= S_CSUM;
`else
                r_state   <= S_DONE;
                r_done    <= 1'b1;
                r_cpu_rst <= 1'b0;
`endif
              end else begin
                r_state <= S_DATA;
              end
            end
          end

          S_DATA: begin
            if (w_fire) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              r_csum     <= r_csum ^ bus.rx_data;
`endif
              r_byte_idx <= r_byte_idx + 2'd1;
              case (r_byte_idx)
                2'd0: r_buf[7:0]   <= bus.rx_data;
                2'd1: r_buf[15:8]  <= bus.rx_data;
                2'd2: r_buf[23:16] <= bus.rx_data;
                default: begin
                  r_imem_we      <= 1'b1;
                  r_imem_wdata   <= {bus.rx_data, r_buf};
                  r_imem_addr    <= r_words_loaded[ADDR_W-1:0];
                  r_words_loaded <= w_next_count;
                  if (w_last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    r_state <= S_CSUM;
`else
                    r_state <= S_FIN;
`endif
                  end
                end
              endcase
            end
          end

          // Single settling cycle so done trails the last write strobe.
          S_FIN: begin
            r_state   <= S_DONE;
            r_done    <= 1'b1;
            r_cpu_rst <= 1'b0;
          end

`ifdef IMEM_LOADER_CHECKSUM_EN
          S_CSUM: begin
            if (w_fire) begin
              if (bus.rx_data == r_csum) begin
                r_state   <= S_DONE;
                r_done    <= 1'b1;
                r_cpu_rst <= 1'b0;
              end else begin
                r_state <= S_ERR;
                r_error <= 1'b1;
              end
            end
          end
`endif

          default: begin
            // DONE and ERR hold until start or rst.
          end
        endcase
      end
    end
  end

  assign bus.rx_ready    = w_rx_ready;
  assign bus.imem_we     = r_imem_we;
  assign bus.imem_addr   = r_imem_addr;
  assign bus.imem_wdata  = r_imem_wdata;
  assign o_cpu_rst       = r_cpu_rst;
  assign o_done          = r_done;
  assign o_error         = r_error;
  assign o_words_loaded  = r_words_loaded;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard testbench for imem_loader
module tb_imem_loader;
  localparam int ADDR_W = 10;

  logic            clk;
  logic            rst;
  logic            start;
  logic            cpu_rst;
  logic            done;
  logic            error;
  logic [ADDR_W:0] words_loaded;

  int checks;
  int errors;
  logic [7:0] tb_csum;
  logic [ADDR_W+31:0] exp_q[$];

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.MEM_DEPTH(1024), .ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_start        (start),
    .bus            (bus.slave),
    .o_cpu_rst      (cpu_rst),
    .o_done         (done),
    .o_error        (error),
    .o_words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && bus.imem_we === 1'b1) begin
      logic [ADDR_W+31:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr %0d data %h expected no write",
                 bus.imem_addr, bus.imem_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({bus.imem_addr, bus.imem_wdata} !== e) begin
          errors++;
          $display("FAIL write: got addr %0d data %h expected addr %0d data %h",
                   bus.imem_addr, bus.imem_wdata, e[ADDR_W+31:32], e[31:0]);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    for (int i = 0; i < gap; i++) @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    #1;
    n = 0;
    while (bus.rx_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (bus.rx_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL send_byte_timeout: got rx_ready %b expected 1", bus.rx_ready);
    end else begin
      @(posedge clk);
      tb_csum = tb_csum ^ b;
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_len(input logic [15:0] n);
    tb_csum = 8'h00;
    send_byte(n[7:0], 0);
    send_byte(n[15:8], 0);
  endtask

  task automatic send_word(input logic [ADDR_W-1:0] addr, input logic [31:0] w, input bit stall);
    exp_q.push_back({addr, w});
    for (int i = 0; i < 4; i++) begin
      logic [7:0] b;
      b = w[8*i +: 8];
      send_byte(b, stall ? int'($urandom_range(0, 3)) : 0);
    end
  endtask

  // Called right after the last payload byte was accepted.
  task automatic finish_stream(input bit empty_image);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(tb_csum, 0);
`else
    if (!empty_image) begin
      chk("done_before_fin", {31'd0, done}, 32'd0);
      @(negedge clk);
    end
`endif
  endtask

  task automatic pulse_start();
    start = 1'b1;
    #1;
    chk("rx_ready_during_start", {31'd0, bus.rx_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    tb_csum = 8'h00;
    rst = 1'b1;
    start = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_error", {31'd0, error}, 32'd0);
    chk("reset_words", 32'(words_loaded), 32'd0);
    chk("reset_we", {31'd0, bus.imem_we}, 32'd0);
    rst = 1'b0;
    #1;
    chk("len0_rx_ready", {31'd0, bus.rx_ready}, 32'd1);

    // Two-word image from the reference stream.
    send_len(16'd2);
    send_word(10'd0, 32'h0050_0013, 1'b0);
    send_word(10'd1, 32'h0000_0233, 1'b0);
    finish_stream(1'b0);
    chk("two_done", {31'd0, done}, 32'd1);
    chk("two_cpu_rst", {31'd0, cpu_rst}, 32'd0);
    chk("two_words", 32'(words_loaded), 32'd2);
    // Extra bytes after DONE are left in the stream.
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("done_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
    end
    bus.rx_valid = 1'b0;
    chk("done_words_hold", 32'(words_loaded), 32'd2);

    // Length 1025 exceeds the memory depth.
    pulse_start();
    chk("start_clears_done", {31'd0, done}, 32'd0);
    send_len(16'd1025);
    chk("len_err_error", {31'd0, error}, 32'd1);
    chk("len_err_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
    chk("len_err_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    chk("len_err_done", {31'd0, done}, 32'd0);

    // Empty image.
    pulse_start();
    chk("start_clears_error", {31'd0, error}, 32'd0);
    send_len(16'd0);
    finish_stream(1'b1);
    chk("empty_done", {31'd0, done}, 32'd1);
    chk("empty_words", 32'(words_loaded), 32'd0);

    // Three words with random rx_valid gaps.
    pulse_start();
    send_len(16'd3);
    send_word(10'd0, 32'hDEAD_BEEF, 1'b1);
    send_word(10'd1, 32'h1234_5678, 1'b1);
    send_word(10'd2, 32'h0000_0001, 1'b1);
    finish_stream(1'b0);
    chk("stall_done", {31'd0, done}, 32'd1);
    chk("stall_words", 32'(words_loaded), 32'd3);

    // start after the 2nd byte of word 1, together with a valid byte.
    pulse_start();
    send_len(16'd2);
    send_word(10'd0, 32'hCAFE_0001, 1'b0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hAA;
    pulse_start();
    bus.rx_valid = 1'b0;
    chk("mid_start_words", 32'(words_loaded), 32'd0);
    chk("mid_start_rx_ready", {31'd0, bus.rx_ready}, 32'd1);
    chk("mid_start_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    send_len(16'd1);
    send_word(10'd0, 32'h0BAD_F00D, 1'b0);
    finish_stream(1'b0);
    chk("restart_done", {31'd0, done}, 32'd1);
    chk("restart_words", 32'(words_loaded), 32'd1);

    // Asynchronous reset mid-word.
    pulse_start();
    send_len(16'd2);
    send_word(10'd0, 32'h7654_3210, 1'b0);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    rst = 1'b1;
    #1;
    chk("rst_words", 32'(words_loaded), 32'd0);
    chk("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    chk("rst_we", {31'd0, bus.imem_we}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    send_len(16'd1);
    send_word(10'd0, 32'h0000_00FF, 1'b0);
    finish_stream(1'b0);
    chk("after_rst_done", {31'd0, done}, 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum of 01 00 13 00 00 00 is 0x12.
    pulse_start();
    send_len(16'd1);
    send_word(10'd0, 32'h0000_0013, 1'b0);
    send_byte(8'h12, 0);
    chk("csum_ok_done", {31'd0, done}, 32'd1);
    chk("csum_ok_error", {31'd0, error}, 32'd0);
    pulse_start();
    send_len(16'd1);
    send_word(10'd0, 32'h0000_0013, 1'b0);
    send_byte(8'h13, 0);
    chk("csum_bad_error", {31'd0, error}, 32'd1);
    chk("csum_bad_done", {31'd0, done}, 32'd0);
    chk("csum_bad_cpu_rst", {31'd0, cpu_rst}, 32'd1);
`endif

    repeat (2) @(negedge clk);
    chk("writes_outstanding", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
